// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - keypad-driven calculator entry FSM; optional signed divide under CALC_DIV_EN
module calc_entry_fsm #(
    parameter int DIGITS = 4,
    parameter int RES_W  = 32
) (
    input  logic                    clk_slow,
    input  logic                    rst_n,
    input  logic                    key_pushed,
    input  logic [3:0]              data_in,
    input  logic [1:0]              key_type,
    output logic signed [RES_W-1:0] display_val,
    output logic                    result_valid,
    output logic                    err,
    output logic [2:0]              entry_state
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_WAIT = 3'd1,
        S_ENTER_B = 3'd2,
        S_RESULT  = 3'd3,
        S_ERROR   = 3'd4,
        S_DIVIDE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_MUL   = 2'd2;
    localparam logic [1:0] KT_DIGIT = 2'b00;
    localparam logic [1:0] KT_OP    = 2'b01;
    localparam logic [1:0] KT_EQ    = 2'b10;
    localparam logic [1:0] KT_CLR   = 2'b11;

    state_t                  state_q, state_d;
    logic signed [RES_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]              op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    key_q, armed_q;

    logic                    key_ev, digit_bad, cnt_full, new_op_bad;
    logic                    do_eval, eval_chain;
    logic [1:0]              new_op;
    logic signed [RES_W-1:0] digit_v, acc_a, acc_b, alu_val;
    logic                    alu_err;
    logic [RES_W:0]          sum_w, diff_w;
    logic signed [2*RES_W-1:0] prod_w;
    logic [RES_W:0]          prod_hi;

`ifdef CALC_DIV_EN
    localparam int DCNT_W = $clog2(RES_W + 1);
    logic [RES_W-1:0]  dq_q, dq_d, dden_q, dden_d, drem_q, drem_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              dneg_q, dneg_d, dchain_q, dchain_d;
    logic [1:0]        dnewop_q, dnewop_d;
    logic [RES_W:0]    d_rem_sh, d_trial;
    logic [RES_W-1:0]  d_quo_nx, d_rem_nx, a_mag, b_mag;
    logic signed [RES_W-1:0] d_quo_s;
    logic              d_ovf;

    // One restoring-division step per cycle on operand magnitudes; sign fixed up at the end
    always_comb begin
        d_rem_sh = {drem_q, dq_q[RES_W-1]};
        d_trial  = d_rem_sh - {1'b0, dden_q};
        d_quo_nx = {dq_q[RES_W-2:0], ~d_trial[RES_W]};
        d_rem_nx = d_trial[RES_W] ? d_rem_sh[RES_W-1:0] : d_trial[RES_W-1:0];
        d_quo_s  = dneg_q ? -$signed(d_quo_nx) : $signed(d_quo_nx);
        d_ovf    = ~dneg_q & d_quo_nx[RES_W-1];
        a_mag    = a_q[RES_W-1] ? $unsigned(-a_q) : $unsigned(a_q);
        b_mag    = b_q[RES_W-1] ? $unsigned(-b_q) : $unsigned(b_q);
    end
`endif

    // A key still held when reset releases is absorbed by armed_q, not seen as a press
    assign key_ev = armed_q & key_pushed & ~key_q;

    always_comb begin
        digit_v    = {{(RES_W-4){1'b0}}, data_in};
        acc_a      = a_q * RES_W'(10) + digit_v;
        acc_b      = b_q * RES_W'(10) + digit_v;
        digit_bad  = data_in > 4'd9;
        cnt_full   = cnt_q >= CNT_W'(DIGITS);
        new_op     = data_in[1:0];
`ifdef CALC_DIV_EN
        new_op_bad = 1'b0;
`else
        new_op_bad = &data_in[1:0];
`endif
        sum_w   = {a_q[RES_W-1], a_q} + {b_q[RES_W-1], b_q};
        diff_w  = {a_q[RES_W-1], a_q} - {b_q[RES_W-1], b_q};
        prod_w  = $signed({{RES_W{a_q[RES_W-1]}}, a_q}) * $signed({{RES_W{b_q[RES_W-1]}}, b_q});
        prod_hi = prod_w[2*RES_W-1:RES_W-1];
        alu_val = '0;
        alu_err = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_val = sum_w[RES_W-1:0];
                alu_err = sum_w[RES_W] ^ sum_w[RES_W-1];
            end
            OP_SUB: begin
                alu_val = diff_w[RES_W-1:0];
                alu_err = diff_w[RES_W] ^ diff_w[RES_W-1];
            end
            OP_MUL: begin
                alu_val = prod_w[RES_W-1:0];
                alu_err = ~((&prod_hi) | ~(|prod_hi));
            end
            default: begin
                alu_val = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            key_q    <= 1'b0;
            armed_q  <= 1'b0;
`ifdef CALC_DIV_EN
            dq_q     <= '0;
            dden_q   <= '0;
            drem_q   <= '0;
            dcnt_q   <= '0;
            dneg_q   <= 1'b0;
            dchain_q <= 1'b0;
            dnewop_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            key_q    <= key_pushed;
            armed_q  <= 1'b1;
`ifdef CALC_DIV_EN
            dq_q     <= dq_d;
            dden_q   <= dden_d;
            drem_q   <= drem_d;
            dcnt_q   <= dcnt_d;
            dneg_q   <= dneg_d;
            dchain_q <= dchain_d;
            dnewop_q <= dnewop_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        do_eval    = 1'b0;
        eval_chain = 1'b0;
`ifdef CALC_DIV_EN
        dq_d       = dq_q;
        dden_d     = dden_q;
        drem_d     = drem_q;
        dcnt_d     = dcnt_q;
        dneg_d     = dneg_q;
        dchain_d   = dchain_q;
        dnewop_d   = dnewop_q;
        if (state_q == S_DIVIDE) begin
            dq_d   = d_quo_nx;
            drem_d = d_rem_nx;
            dcnt_d = dcnt_q - DCNT_W'(1);
            if (dcnt_q == DCNT_W'(1)) begin
                if (d_ovf) begin
                    state_d = S_ERROR;
                end else if (dchain_q) begin
                    a_d     = d_quo_s;
                    op_d    = dnewop_q;
                    cnt_d   = '0;
                    state_d = S_OP_WAIT;
                end else begin
                    res_d   = d_quo_s;
                    state_d = S_RESULT;
                end
            end
        end else
`endif
        if (key_ev && key_type == KT_CLR) begin
            state_d = S_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            res_d   = '0;
            op_d    = OP_ADD;
            cnt_d   = '0;
        end else if (key_ev) begin
            case (state_q)
                S_ENTER_A: begin
                    if (key_type == KT_DIGIT) begin
                        if (digit_bad) begin
                            state_d = S_ERROR;
                        end else if (!cnt_full) begin
                            a_d   = acc_a;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (key_type == KT_OP) begin
                        op_d    = new_op;
                        state_d = new_op_bad ? S_ERROR : S_OP_WAIT;
                    end else if (key_type == KT_EQ) begin
                        res_d   = a_q;
                        state_d = S_RESULT;
                    end
                end
                S_OP_WAIT: begin
                    if (key_type == KT_DIGIT) begin
                        if (digit_bad) begin
                            state_d = S_ERROR;
                        end else begin
                            b_d     = digit_v;
                            cnt_d   = CNT_W'(1);
                            state_d = S_ENTER_B;
                        end
                    end else if (key_type == KT_OP) begin
                        op_d = new_op;
                        if (new_op_bad) state_d = S_ERROR;
                    end
                end
                S_ENTER_B: begin
                    if (key_type == KT_DIGIT) begin
                        if (digit_bad) begin
                            state_d = S_ERROR;
                        end else if (!cnt_full) begin
                            b_d   = acc_b;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (key_type == KT_OP) begin
                        if (new_op_bad) state_d = S_ERROR;
                        else begin
                            do_eval    = 1'b1;
                            eval_chain = 1'b1;
                        end
                    end else if (key_type == KT_EQ) begin
                        do_eval = 1'b1;
                    end
                end
                S_RESULT: begin
                    if (key_type == KT_DIGIT) begin
                        if (digit_bad) begin
                            state_d = S_ERROR;
                        end else begin
                            a_d     = digit_v;
                            cnt_d   = CNT_W'(1);
                            state_d = S_ENTER_A;
                        end
                    end else if (key_type == KT_OP) begin
                        a_d     = res_q;
                        op_d    = new_op;
                        state_d = new_op_bad ? S_ERROR : S_OP_WAIT;
                    end
                end
                default: ;
            endcase
        end

        if (do_eval) begin
            if (&op_q) begin
`ifdef CALC_DIV_EN
                if (b_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    state_d  = S_DIVIDE;
                    dq_d     = a_mag;
                    dden_d   = b_mag;
                    drem_d   = '0;
                    dcnt_d   = DCNT_W'(RES_W);
                    dneg_d   = a_q[RES_W-1] ^ b_q[RES_W-1];
                    dchain_d = eval_chain;
                    dnewop_d = new_op;
                end
`else
                state_d = S_ERROR;
`endif
            end else if (alu_err) begin
                state_d = S_ERROR;
            end else if (eval_chain) begin
                a_d     = alu_val;
                op_d    = new_op;
                cnt_d   = '0;
                state_d = S_OP_WAIT;
            end else begin
                res_d   = alu_val;
                state_d = S_RESULT;
            end
        end
    end

    always_comb begin
        case (state_q)
            S_ENTER_A, S_OP_WAIT: display_val = a_q;
            S_ENTER_B:            display_val = b_q;
            S_RESULT:             display_val = res_q;
            default:              display_val = '0;
        endcase
        result_valid = state_q == S_RESULT;
        err          = state_q == S_ERROR;
        entry_state  = state_q;
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - randomized self-checking bench for calc_entry_fsm against a behavioural model
module tb_calc_entry_fsm;
    logic               clk_slow = 1'b0;
    logic               rst_n = 1'b0;
    logic               key_pushed = 1'b0;
    logic [3:0]         data_in = 4'd0;
    logic [1:0]         key_type = 2'd0;
    logic signed [31:0] display_val;
    logic               result_valid;
    logic               err;
    logic [2:0]         entry_state;

    int checks = 0;
    int failures = 0;

    calc_entry_fsm #(.DIGITS(4), .RES_W(32)) dut (
        .clk_slow(clk_slow), .rst_n(rst_n), .key_pushed(key_pushed),
        .data_in(data_in), .key_type(key_type), .display_val(display_val),
        .result_valid(result_valid), .err(err), .entry_state(entry_state)
    );

    always #5 clk_slow = ~clk_slow;

    // Model: state numbers are the calculator modes 0 A-entry, 1 op-wait, 2 B-entry, 3 result, 4 error
    int     m_state;
    longint m_a, m_b, m_res;
    int     m_op, m_cnt;

    function automatic bit fits(input longint v);
        return v >= -64'sd2147483648 && v <= 64'sd2147483647;
    endfunction

    function automatic bit calc(input int op, input longint a, input longint b, output longint v);
        v = 0;
        case (op)
            0: v = a + b;
            1: v = a - b;
            2: v = a * b;
            default: return 1'b0;
        endcase
        return fits(v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_cnt = 0;
    endtask

    task automatic model_key(input int t, input int d);
        longint v;
        int     nop;
        nop = d % 4;
        if (t == 3) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (t == 0) begin
                   if (d > 9) m_state = 4;
                   else if (m_cnt < 4) begin m_a = m_a * 10 + d; m_cnt++; end
               end else if (t == 1) begin
                   m_op = nop; m_state = (nop == 3) ? 4 : 1;
               end else begin
                   m_res = m_a; m_state = 3;
               end
            1: if (t == 0) begin
                   if (d > 9) m_state = 4;
                   else begin m_b = d; m_cnt = 1; m_state = 2; end
               end else if (t == 1) begin
                   m_op = nop; if (nop == 3) m_state = 4;
               end
            2: if (t == 0) begin
                   if (d > 9) m_state = 4;
                   else if (m_cnt < 4) begin m_b = m_b * 10 + d; m_cnt++; end
               end else if (t == 2) begin
                   if (calc(m_op, m_a, m_b, v)) begin m_res = v; m_state = 3; end
                   else m_state = 4;
               end else begin
                   if (nop == 3) m_state = 4;
                   else if (calc(m_op, m_a, m_b, v)) begin m_a = v; m_op = nop; m_cnt = 0; m_state = 1; end
                   else m_state = 4;
               end
            3: if (t == 0) begin
                   if (d > 9) m_state = 4;
                   else begin m_a = d; m_cnt = 1; m_state = 0; end
               end else if (t == 1) begin
                   m_a = m_res; m_op = nop; m_state = (nop == 3) ? 4 : 1;
               end
            default: ;
        endcase
    endtask

    function automatic logic [36:0] exp_vec();
        logic [31:0] d;
        case (m_state)
            0, 1:    d = m_a[31:0];
            2:       d = m_b[31:0];
            3:       d = m_res[31:0];
            default: d = 32'd0;
        endcase
        return {d, m_state == 3, m_state == 4, 3'(m_state)};
    endfunction

    task automatic press(input int t, input int d, input int hold, input int gap);
        @(posedge clk_slow); #1;
        key_type = 2'(t); data_in = 4'(d); key_pushed = 1'b1;
        model_key(t, d);
        repeat (hold) @(posedge clk_slow);
        #1 key_pushed = 1'b0;
        repeat (gap) @(posedge clk_slow);
        @(negedge clk_slow);
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        rst_n = 1'b0;
        model_reset();
        #1;
        obs = {display_val, result_valid, err, entry_state};
        if (obs !== 37'd0) begin
            $display("FAIL reset_state got=%h want=%h", obs, 37'd0); failures++;
        end
        checks++;
        repeat (3) @(negedge clk_slow);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_slow);
    endtask

    task automatic test_basic_add();
        int keys_t[5] = '{0, 0, 1, 0, 2};
        int keys_d[5] = '{1, 8, 0, 6, 0};
        int want[5]   = '{1, 18, 18, 6, 24};
        logic [36:0] obs;
        for (int i = 0; i < 5; i++) begin
            press(keys_t[i], keys_d[i], 10, 20);
            obs = {display_val, result_valid, err, entry_state};
            if (obs !== exp_vec() || display_val !== want[i]) begin
                $display("FAIL basic_add[%0d] got=%h want=%h disp_want=%0d", i, obs, exp_vec(), want[i]);
                failures++;
            end
            checks++;
        end
        if (result_valid !== 1'b1 || err !== 1'b0) begin
            $display("FAIL basic_add_flags got rv=%b err=%b want rv=1 err=0", result_valid, err); failures++;
        end
        checks++;
    endtask

    task automatic test_held_key();
        press(3, 0, 2, 4);
        press(0, 5, 50, 20);
        if (display_val !== 32'sd5 || {display_val, result_valid, err, entry_state} !== exp_vec()) begin
            $display("FAIL held_key got=%0d want=5", display_val); failures++;
        end
        checks++;
    endtask

    task automatic test_digit_limit_mul();
        press(3, 0, 2, 4);
        for (int i = 0; i < 5; i++) press(0, 9, 2, 3);
        if (display_val !== 32'sd9999) begin
            $display("FAIL digit_limit got=%0d want=9999", display_val); failures++;
        end
        checks++;
        press(1, 2, 2, 3);
        for (int i = 0; i < 4; i++) press(0, 9, 2, 3);
        press(2, 0, 2, 3);
        if (display_val !== 32'sd99980001 || result_valid !== 1'b1 || err !== 1'b0) begin
            $display("FAIL mul_9999 got=%0d rv=%b want=99980001 rv=1", display_val, result_valid); failures++;
        end
        checks++;
    endtask

    task automatic test_chain_result();
        press(3, 0, 2, 4);
        press(0, 3, 2, 3); press(1, 1, 2, 3); press(0, 7, 2, 3); press(2, 0, 2, 3);
        if (display_val !== -32'sd4 || result_valid !== 1'b1) begin
            $display("FAIL sub_neg got=%0d rv=%b want=-4 rv=1", display_val, result_valid); failures++;
        end
        checks++;
        press(1, 0, 2, 3); press(0, 2, 2, 3); press(2, 0, 2, 3);
        if (display_val !== -32'sd2 || result_valid !== 1'b1) begin
            $display("FAIL chain_result got=%0d want=-2", display_val); failures++;
        end
        checks++;
    endtask

    task automatic test_chain_op();
        press(3, 0, 2, 4);
        press(0, 2, 2, 3); press(1, 0, 2, 3); press(0, 3, 2, 3); press(1, 2, 2, 3);
        if (display_val !== 32'sd5 || entry_state !== 3'd1) begin
            $display("FAIL chain_op got=%0d state=%0d want=5 state=1", display_val, entry_state); failures++;
        end
        checks++;
        press(0, 4, 2, 3); press(2, 0, 2, 3);
        if (display_val !== 32'sd20 || result_valid !== 1'b1) begin
            $display("FAIL chain_op_result got=%0d want=20", display_val); failures++;
        end
        checks++;
    endtask

    task automatic test_error_clear();
        press(3, 0, 2, 4);
        press(0, 12, 2, 3);
        if (err !== 1'b1 || display_val !== 32'sd0 || entry_state !== 3'd4) begin
            $display("FAIL bad_digit got err=%b disp=%0d state=%0d want err=1 disp=0 state=4", err, display_val, entry_state);
            failures++;
        end
        checks++;
        press(0, 3, 2, 3);
        press(2, 0, 2, 3);
        if (err !== 1'b1 || display_val !== 32'sd0) begin
            $display("FAIL error_sticky got err=%b disp=%0d want err=1 disp=0", err, display_val); failures++;
        end
        checks++;
        press(3, 0, 2, 3);
        if (err !== 1'b0 || entry_state !== 3'd0 || display_val !== 32'sd0) begin
            $display("FAIL clear_exit got err=%b state=%0d want err=0 state=0", err, entry_state); failures++;
        end
        checks++;
        press(0, 8, 2, 3); press(1, 3, 2, 3);
        if (err !== 1'b1) begin
            $display("FAIL op3_no_div got err=%b want 1", err); failures++;
        end
        checks++;
        press(3, 0, 2, 3);
        press(0, 5, 2, 3); press(1, 0, 2, 3); press(0, 2, 2, 3);
        press(0, 0, 2, 3); press(0, 0, 2, 3); press(1, 2, 2, 3); // A = 5+200 = 205
        press(0, 9, 2, 3); press(0, 9, 2, 3); press(0, 9, 2, 3); press(0, 9, 2, 3);
        press(1, 2, 2, 3); // 205*9999 = 2049795
        press(0, 9, 2, 3); press(0, 9, 2, 3); press(0, 9, 2, 3); press(0, 9, 2, 3);
        press(2, 0, 2, 3); // 2049795*9999 overflows 32 bits
        if (err !== 1'b1 || {display_val, result_valid, err, entry_state} !== exp_vec()) begin
            $display("FAIL mul_overflow got err=%b disp=%0d want err=1", err, display_val); failures++;
        end
        checks++;
    endtask

    task automatic test_async_reset();
        logic [36:0] obs;
        press(3, 0, 2, 4);
        press(0, 4, 2, 3); press(0, 2, 2, 3);
        #2 rst_n = 1'b0;
        #1 obs = {display_val, result_valid, err, entry_state};
        if (obs !== 37'd0) begin
            $display("FAIL async_reset got=%h want=0", obs); failures++;
        end
        checks++;
        model_reset();
        key_type = 2'd0; data_in = 4'd7; key_pushed = 1'b1;
        repeat (3) @(negedge clk_slow);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_slow);
        obs = {display_val, result_valid, err, entry_state};
        if (obs !== exp_vec()) begin
            $display("FAIL held_at_release got=%h want=%h", obs, exp_vec()); failures++;
        end
        checks++;
        key_pushed = 1'b0;
        repeat (3) @(negedge clk_slow);
        press(0, 6, 2, 3);
        if (display_val !== 32'sd6) begin
            $display("FAIL after_release got=%0d want=6", display_val); failures++;
        end
        checks++;
    endtask

    task automatic test_random();
        logic [36:0] obs;
        int r, t, d;
        press(3, 0, 1, 2);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                t = 0;
                d = ($urandom_range(0, 24) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            end else if (r < 72) begin
                t = 1;
                d = ($urandom_range(0, 11) == 0) ? 3 + 4 * $urandom_range(0, 3) : $urandom_range(0, 2) + 4 * $urandom_range(0, 3);
            end else if (r < 92) begin
                t = 2; d = $urandom_range(0, 15);
            end else begin
                t = 3; d = $urandom_range(0, 15);
            end
            press(t, d, $urandom_range(1, 3), $urandom_range(1, 3));
            obs = {display_val, result_valid, err, entry_state};
            if (obs !== exp_vec()) begin
                $display("FAIL random[%0d] key t=%0d d=%0d got=%h want=%h", i, t, d, obs, exp_vec());
                failures++;
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_held_key();
        test_digit_limit_mul();
        test_chain_result();
        test_chain_op();
        test_error_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end
endmodule
